// File: rtl/seq_mult4_if.sv
// Handshake and operand/result bundle for the seq_mult4 shift-and-add multiplier.
// The master side issues start with operands; the slave side returns product and status.
interface seq_mult4_if;
   logic       start;
   logic [3:0] A;
   logic [3:0] B;
   logic [7:0] P;
   logic       busy;
   logic       done;

   modport master (
      output start,
      output A,
      output B,
      input  P,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  A,
      input  B,
      output P,
      output busy,
      output done
   );
endinterface

// File: rtl/seq_mult4.sv
// Sequential 4x4 unsigned shift-and-add multiplier: one ripple add per clock, four
// iterations per product, start/busy/done handshake with fully registered outputs.
module seq_mult4 (
   input  logic         clk,
   input  logic         rst_n,
   seq_mult4_if.slave   bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0] state_q, state_d;
   logic [3:0] m_q, m_d;
   logic [3:0] q_q, q_d;
   logic [3:0] acc_q, acc_d;
   logic [2:0] count_q, count_d;
   logic [7:0] p_q, p_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic [3:0] addend_s;
   logic [4:0] sum_s;

   // 4-bit ripple-carry adder; bit 4 of the result is the carry-out.
   function automatic logic [4:0] add4(input logic [3:0] x, input logic [3:0] y);
      logic [4:0] c;
      logic [3:0] s;
      c[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
      return {c[4], s};
   endfunction

   // Datapath adder: accumulator high half plus the multiplicand gated by the current multiplier LSB.
   always_comb begin
      addend_s = q_q[0] ? m_q : 4'b0000;
      sum_s    = add4(acc_q, addend_s);
   end

   // Next-state logic; busy/done are computed one cycle early so they register alongside the state.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      q_d     = q_q;
      acc_d   = acc_q;
      count_d = count_q;
      p_d     = p_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               m_d     = bus.A;
               q_d     = bus.B;
               acc_d   = 4'h0;
               count_d = 3'd0;
               state_d = ST_CALC;
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            // Carry-out shifts into ACC[3] and the sum LSB drops into the multiplier register.
            acc_d   = {sum_s[4], sum_s[3:1]};
            q_d     = {sum_s[0], q_q[3:1]};
            count_d = count_q + 3'd1;
            if (count_q == 3'd3) begin
               p_d     = {acc_d, q_d};
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_CALC;
               busy_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            m_d     = 4'h0;
            q_d     = 4'h0;
            acc_d   = 4'h0;
            count_d = 3'd0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         m_q     <= 4'h0;
         q_q     <= 4'h0;
         acc_q   <= 4'h0;
         count_q <= 3'd0;
         p_q     <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         q_q     <= q_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         p_q     <= p_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.P    = p_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: doc/seq_mult4.md
Name: seq_mult4

Overview:
Sequential 4x4 unsigned shift-and-add multiplier. It performs one 4-bit add per clock through a combinational 4-bit ripple adder with carry-out: the accumulator high nibble and the multiplicand feed the adder, and the registered result consumes the adder's sum and carry. It produces an 8-bit product after 4 add/shift cycles, with a start/busy/done handshake toward the surrounding control logic.

Parameters:
None. Width is fixed at 4x4 to 8 to match the 4-bit adder datapath.

Ports:
clk    input   1  rising-edge clock
rst_n  input   1  synchronous reset, active-low, sampled on rising clk
start  input   1  request; sampled only in IDLE
A      input   4  multiplicand, unsigned; latched on accepted start
B      input   4  multiplier, unsigned; latched on accepted start
P      output  8  product, registered; holds last result until next completion
busy   output  1  high while state is CALC
done   output  1  one-cycle pulse; P is valid and newly updated

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State becomes IDLE.
  - P=8'h00, busy=0, done=0.
  - Internal regs M, Q, ACC, count all cleared.
  - Reset overrides every other input in that cycle.
- Internal registers:
  - M[3:0]: latched multiplicand.
  - Q[3:0]: multiplier, which shifts into the product low half.
  - ACC[3:0]: product high half.
  - count[2:0]: iteration counter.
- States are IDLE, CALC and DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at an edge: M<=A, Q<=B, ACC<=0, count<=0, go to CALC.
  - Otherwise stay in IDLE.
- CALC, one iteration per edge:
  - Adder inputs are ACC and (Q[0] ? M : 4'b0), with carry-in 0, giving {C,S}.
  - Update ACC<={C,S[3:1]}, Q<={S[0],Q[3:1]}, count<=count+1.
  - On the edge where count==3 (4th iteration), also load P<={new ACC,new Q} and go to DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle.
  - Next edge goes unconditionally to IDLE.
  - start is ignored in DONE.
- Latency:
  - start is accepted at edge E0.
  - busy is high in the cycles after E0..E3 (4 cycles).
  - P updates and done rises at E4; done falls at E5.
  - Minimum issue interval is 6 edges: with start held high, the next accept is at E6 (IDLE entered at E5, start sampled at E6).
- Arithmetic:
  - Unsigned only. Carry-out C is never lost; it shifts into ACC[3].
  - Result is exact for all 256 operand pairs; maximum is 15*15=225=8'hE1.
- Operand stability: A and B are ignored outside the accepting edge. Changes during CALC/DONE do not affect the in-flight result.
- start while busy: ignored, with no queueing.
- Reset mid-operation: the operation is aborted, no done pulse is issued, and P clears to 0.
- busy and done are never high simultaneously.
- Zero operands take the same 4-iteration latency; there is no early termination.

Test Plan:
1. Reset, then start with A=4'hF, B=4'hF for one cycle -> busy high 4 cycles; at E4 P=8'hE1, done=1 for exactly one cycle; P holds 8'hE1 afterward.
2. A=4'h6, B=4'h7 -> P=8'h2A (42). Then A=4'h0, B=4'h9 -> P=8'h00, also after 4 busy cycles.
3. Start A=4'h3, B=4'h5; change A=4'hF, B=4'hF and pulse start during CALC and DONE -> P=8'h0F (15); no second operation begins until IDLE.
4. Hold start=1 continuously with A=4'h2, B=4'h8 -> done pulses every 6 cycles; P=8'h10 each time; busy is never high in the same cycle as done.
5. Start A=4'hC, B=4'hB; assert rst_n=0 at the 2nd CALC cycle -> P=0, busy=0, done=0 next cycle, and no done pulse follows. A new start after release with A=4'hC, B=4'hB gives P=8'h84 (132).
6. Exhaustive sweep of all 256 (A,B) pairs, back-to-back -> every P equals A*B; each done lands exactly 4 edges after its accept edge.
